// File: rtl/sevseg_pkg.sv
// sevseg_pkg -- constants shared by the eight-digit seven-segment scanner.
//   NUM_DIGITS   : number of multiplexed digits
//   SEG_HEX_x    : active-low segment codes {g,f,e,d,c,b,a} for hex digit x
//   SEG_BLANK    : all segments off
//   AN_OFF       : all anodes off
//   anode_sel()  : one-hot active-low anode pattern for a digit index
package sevseg_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

  function automatic logic [7:0] anode_sel(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/sevseg_hex7seg.sv
// hex7seg -- combinational hex to active-low seven-segment decoder.
//   hex : 4-bit hex digit
//   seg : segments {g,f,e,d,c,b,a}, active low
module hex7seg
  import sevseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Lookup of the segment pattern for each hex value.
  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0:    seg = SEG_HEX_0;
      4'h1:    seg = SEG_HEX_1;
      4'h2:    seg = SEG_HEX_2;
      4'h3:    seg = SEG_HEX_3;
      4'h4:    seg = SEG_HEX_4;
      4'h5:    seg = SEG_HEX_5;
      4'h6:    seg = SEG_HEX_6;
      4'h7:    seg = SEG_HEX_7;
      4'h8:    seg = SEG_HEX_8;
      4'h9:    seg = SEG_HEX_9;
      4'hA:    seg = SEG_HEX_A;
      4'hB:    seg = SEG_HEX_B;
      4'hC:    seg = SEG_HEX_C;
      4'hD:    seg = SEG_HEX_D;
      4'hE:    seg = SEG_HEX_E;
      4'hF:    seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevseg_scan.sv
// sevseg_scan -- time-multiplexed scanner for an eight-digit seven-segment
// display. Each digit owns CLK_DIV clocks; the displayed value is frozen
// for a whole eight-digit frame so a mid-frame update never tears.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   en_i   : display enable, low blanks everything
//   data_i : eight hex nibbles, nibble k = data_i[4k+3:4k]
//   dp_i   : per-digit decimal point request, active high
//   an_o   : registered anode select, active low, bit 0 = rightmost digit
//   seg_o  : registered segments {g,f,e,d,c,b,a}, active low
//   dp_o   : registered decimal point, active low
// Optional build macro SEVSEG_LZ_BLANK_EN: blank leading-zero digits.
module sevseg_scan
  import sevseg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 20000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  logic [15:0] presc_r;
  logic        tick_s;
  logic [2:0]  idx_r;
  logic [31:0] snap_data_r;
  logic [7:0]  snap_dp_r;
  logic [3:0]  nib_s;
  logic [6:0]  dec_s;
  logic        lit_s;
  logic [7:0]  an_s;
  logic [6:0]  seg_s;
  logic        dp_s;

  assign tick_s = (presc_r == 16'(CLK_DIV - 1));

  // Prescaler: counts clocks within one digit slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_r <= 16'd0;
    end else if (tick_s) begin
      presc_r <= 16'd0;
    end else begin
      presc_r <= presc_r + 16'd1;
    end
  end

  // Digit index; the frame snapshot is taken when the index wraps to 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_r       <= 3'd0;
      snap_data_r <= 32'h0;
      snap_dp_r   <= 8'h00;
    end else if (tick_s) begin
      idx_r <= idx_r + 3'd1;
      if (idx_r == 3'd7) begin
        snap_data_r <= data_i;
        snap_dp_r   <= dp_i;
      end else begin
        snap_data_r <= snap_data_r;
        snap_dp_r   <= snap_dp_r;
      end
    end else begin
      idx_r <= idx_r;
    end
  end

  assign nib_s = snap_data_r[{idx_r, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .hex (nib_s),
    .seg (dec_s)
  );

`ifdef SEVSEG_LZ_BLANK_EN
  // A digit is a leading zero when it and every more significant nibble
  // are zero; digit 0 and digits with a decimal point stay lit.
  assign lit_s = (idx_r == 3'd0) || snap_dp_r[idx_r] ||
                 ((snap_data_r >> {idx_r, 2'b00}) != 32'h0);
`else
  assign lit_s = 1'b1;
`endif

  // Next output pattern for the current slot.
  always_comb begin
    an_s  = AN_OFF;
    seg_s = SEG_BLANK;
    dp_s  = 1'b1;
    if (en_i && lit_s) begin
      an_s  = anode_sel(idx_r);
      seg_s = dec_s;
      dp_s  = ~snap_dp_r[idx_r];
    end else begin
      an_s  = AN_OFF;
      seg_s = SEG_BLANK;
      dp_s  = 1'b1;
    end
  end

  // Output registers: glitch-free drive of the display pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_o  <= AN_OFF;
      seg_o <= SEG_BLANK;
      dp_o  <= 1'b1;
    end else begin
      an_o  <= an_s;
      seg_o <= seg_s;
      dp_o  <= dp_s;
    end
  end

endmodule

// File: tb/tb_sevseg_scan.sv
// tb_sevseg_scan -- self-checking bench for sevseg_scan with CLK_DIV = 4.
// A cycle-level reference model derived from elapsed clocks since reset
// checks every cycle; directed sequences and a decode table cover the
// named corner cases. Define SEVSEG_LZ_BLANK_EN to test leading-zero blanking.
module tb_sevseg_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [31:0] data = 32'h0;
  logic [7:0]  dp = 8'h00;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dpo;

  int vectors = 0;
  int miscompares = 0;

  sevseg_scan #(.CLK_DIV(DIV)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en),
    .data_i (data),
    .dp_i   (dp),
    .an_o   (an),
    .seg_o  (seg),
    .dp_o   (dpo)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         k = 0;           // clock edges since reset released
  int         mi;
  bit         lit;
  logic [31:0] m_snap = 32'h0;
  logic [7:0]  m_dp = 8'h00;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  bit          chk_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      k = 0; m_snap = 32'h0; m_dp = 8'h00;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      mi = (k / DIV) % 8;
      lit = 1'b1;
`ifdef SEVSEG_LZ_BLANK_EN
      if (mi != 0 && !m_dp[mi]) begin
        lit = 1'b0;
        for (int j = mi; j < 8; j++)
          if (((m_snap >> (4 * j)) & 32'hF) != 32'h0) lit = 1'b1;
      end
`endif
      if (en && lit) begin
        e_an = ~(8'h01 << mi);
        e_seg = seg_ref[(m_snap >> (4 * mi)) & 32'hF];
        e_dp = ~m_dp[mi];
      end else begin
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      end
      k = k + 1;
      if (k % (8 * DIV) == 0) begin
        m_snap = data;
        m_dp = dp;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if ({an, seg, dpo} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        if (miscompares < 20)
          $display("FAIL model t=%0t an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                   $time, an, seg, dpo, e_an, e_seg, e_dp);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Advance to the first cycle in which slot s is on the outputs.
  task automatic goto_slot(input int s);
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!(k > 0 && (k - 1) % DIV == 0 && ((k - 1) / DIV) % 8 == s) && n < 200);
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL goto_slot timeout got=%0d required=%0d", k, s);
    end
  endtask

  typedef struct packed {
    logic [3:0] nib;
    logic [6:0] seg;
  } dec_vec_t;

  dec_vec_t tbl [16];

  initial begin
    tbl = '{'{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
            '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
            '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h08}, '{4'hB, 7'h03},
            '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h0E}};

    // Reset and basic scan
    step(1);
    chk_on = 1'b1;
    step(2);
    check("reset_an", an, 8'hFF);
    check("reset_seg", {1'b0, seg}, 8'h7F);
    check("reset_dp", {7'h0, dpo}, 8'h01);
    rst = 1'b0;
    step(1);
    check("first_an", an, 8'hFE);
    check("first_seg", {1'b0, seg}, 8'h40);
    for (int j = 1; j <= 8; j++) begin
      step(DIV);
      check("scan_an", an, ~(8'h01 << (j % 8)));
    end

    // Decode table, one frame per entry
    for (int i = 0; i < 16; i++) begin
      data = {8{tbl[i].nib}};
      goto_slot(0);
      check("decode_seg", {1'b0, seg}, {1'b0, tbl[i].seg});
    end

    // Frame contents
    data = 32'h89ABCDEF;
    goto_slot(0);
    check("frame_s0", {1'b0, seg}, 8'h0E);
    goto_slot(5);
    check("frame_s5", {1'b0, seg}, 8'h08);
    goto_slot(7);
    check("frame_s7", {1'b0, seg}, 8'h00);

    // No tearing on a mid-frame update
    goto_slot(3);
    data = 32'h0;
    check("tear_s3", {1'b0, seg}, 8'h46);
    goto_slot(4);
    check("tear_s4", {1'b0, seg}, 8'h03);
    goto_slot(5);
    check("tear_s5", {1'b0, seg}, 8'h08);
    goto_slot(6);
    check("tear_s6", {1'b0, seg}, 8'h10);
    goto_slot(7);
    check("tear_s7", {1'b0, seg}, 8'h00);
    goto_slot(0);
    check("tear_new_s0", {1'b0, seg}, 8'h40);

    // Enable off in slot 2, back on in slot 5
    goto_slot(2);
    en = 1'b0;
    step(1);
    check("en_off_an", an, 8'hFF);
    check("en_off_seg", {1'b0, seg}, 8'h7F);
    goto_slot(5);
    en = 1'b1;
    step(1);
    check("en_on_an", an, 8'hDF);

    // Decimal point on digit 2 only
    dp = 8'h04;
    goto_slot(0);
    goto_slot(1);
    check("dp_s1", {7'h0, dpo}, 8'h01);
    goto_slot(2);
    check("dp_s2", {7'h0, dpo}, 8'h00);
    goto_slot(3);
    check("dp_s3", {7'h0, dpo}, 8'h01);

    // Leading zeros
    dp = 8'h00;
    data = 32'h00000012;
    goto_slot(0);
    check("lz_s0_seg", {1'b0, seg}, 8'h24);
    goto_slot(1);
    check("lz_s1_seg", {1'b0, seg}, 8'h79);
    goto_slot(2);
`ifdef SEVSEG_LZ_BLANK_EN
    check("lz_s2_an", an, 8'hFF);
    goto_slot(7);
    check("lz_s7_an", an, 8'hFF);
`else
    check("lz_s2_an", an, 8'hFB);
    check("lz_s2_seg", {1'b0, seg}, 8'h40);
    goto_slot(7);
    check("lz_s7_an", an, 8'h7F);
`endif

    // Reset mid-frame in slot 6
    goto_slot(6);
    rst = 1'b1;
    step(1);
    check("midrst_an", an, 8'hFF);
    check("midrst_seg", {1'b0, seg}, 8'h7F);
    check("midrst_dp", {7'h0, dpo}, 8'h01);
    step(1);
    rst = 1'b0;
    step(1);
    check("postrst_an", an, 8'hFE);
    check("postrst_seg", {1'b0, seg}, 8'h40);
    step(DIV - 1);
    check("postrst_hold", an, 8'hFE);
    step(1);
    check("postrst_next", an, 8'hFD);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if ($urandom_range(0, 15) == 0) data = $urandom >> (4 * $urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) dp = 8'($urandom);
      if ($urandom_range(0, 19) == 0) en = ~en;
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sevseg_scan.md
SEVSEG_SCAN -- requirements
Module: sevseg_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 20000, clocks per digit slot (legal range 2..65535).
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en_i  input  1  display enable; low blanks all digits.
REQ-005 SHALL have port data_i  input  32  eight hex nibbles from the GPIO output register; nibble k = data_i[4k+3:4k].
REQ-006 SHALL have port dp_i  input  8  per-digit decimal-point request, bit k for digit k, active high.
REQ-007 SHALL have port an_o  output  8  registered digit anode select, active low, bit k = digit k (digit 0 rightmost).
REQ-008 SHALL have port seg_o  output  7  registered segments {g,f,e,d,c,b,a}, active low.
REQ-009 SHALL have port dp_o  output  1  registered decimal point, active low.

Function
REQ-010 SHALL count prescaler 0..CLK_DIV-1 and assert an internal tick in the cycle the count equals CLK_DIV-1; the count then wraps to 0.
REQ-011 SHALL advance a 3-bit digit index on each tick, wrapping 7 -> 0.
REQ-012 SHALL capture data_i and dp_i into frame snapshot registers on the tick that wraps the index 7 -> 0; snapshot is stable for the whole 8-slot frame (no tearing).
REQ-013 SHALL drive outputs one cycle after index/snapshot: an_o = ~(1 << index), seg_o = decode(snapshot nibble[index]), dp_o = ~snapshot_dp[index].
REQ-014 SHALL decode hex to active-low codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, 7 bits).
REQ-015 SHALL, when en_i is low, drive an_o=8'hFF, seg_o=7'h7F, dp_o=1 from the next cycle; prescaler, index and snapshot keep running.
REQ-016 SHALL, when en_i rises, resume the current index's display from the next cycle without restarting the frame.
REQ-017 SHALL, for exactly one active anode bit and seg_o, change only in the cycle after a tick or an en_i change.

Reset
REQ-018 SHALL on rst_i clear prescaler to 0, index to 0, snapshots to 0, and set an_o=8'hFF, seg_o=7'h7F, dp_o=1.
REQ-019 SHALL, with rst_i asserted mid-frame, abandon the frame; the first cycle after deassertion shows digit 0 of snapshot 0 (an_o=FE, seg_o=40) if en_i=1.

Configuration
REQ-020 SHALL support macro SEVSEG_LZ_BLANK_EN: when defined, digits k=7..1 whose snapshot nibble and all higher nibbles are zero have their anode held high (seg_o=7F, dp_o=1) in their slot unless their dp bit is set; digit 0 always lit.
REQ-021 SHALL, without SEVSEG_LZ_BLANK_EN, display all eight digits including leading zeros.

Structure
REQ-022 SHALL place digit count (8), segment-code constants, and the blank code 7'h7F in shared package sevseg_pkg.
REQ-023 SHALL instantiate one combinational sub-module hex7seg (4-bit in, 7-bit active-low out) for the decode.

Verification (CLK_DIV=4)
REQ-024 SHALL check: reset then en_i=1, data_i=0 -> an_o=FF during reset, then FE with seg_o=40; anode steps FE,FD,FB..7F every 4 cycles, wraps to FE.
REQ-025 SHALL check: data_i=89ABCDEF, wait one frame -> slot 0 seg_o=0E, slot 7 seg_o=00, slot 5 seg_o=08.
REQ-026 SHALL check: change data_i to 0 during slot 3 -> slots 3..7 of the current frame unchanged; new value shown from next slot 0.
REQ-027 SHALL check: en_i low in slot 2 -> an_o=FF, seg_o=7F next cycle; en_i high in slot 5 -> an_o=DF next cycle.
REQ-028 SHALL check: dp_i=8'h04 -> dp_o=0 only in slot 2; with SEVSEG_LZ_BLANK_EN, data_i=00000012 -> slots 2..7 an_o=FF, slot 1 seg_o=79, slot 0 seg_o=24.
REQ-029 SHALL check: rst_i pulsed in slot 6 -> outputs FF/7F/1 during reset, then slot 0 with seg_o=40 and prescaler restart from 0.
